// File: rtl/sleep_clkgate_pkg.sv
// Shared state encoding and widths for the sleep-aware clock-gating controller.
package sleep_clkgate_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_ENTRY = 2'b01,
        ST_GATED = 2'b10,
        ST_WAKE  = 2'b11
    } sleep_state_e;

    localparam int DLY_W   = 8;
    localparam int STATS_W = 16;

endpackage

// File: rtl/sleep_clkgate_dlycnt.sv
// Loadable 8-bit down-counter shared by the entry and wake delays; holds at zero.
module sleep_clkgate_dlycnt
    import sleep_clkgate_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [DLY_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [DLY_W-1:0] cnt_q;
    logic [DLY_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - DLY_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/sleep_clkgate_ctrl.sv
// Sleep-aware HCLK enable controller (RUN/ENTRY/GATED/WAKE) driving the gate cell CLKEN.
// Optional gated-cycle statistics counter is built when SLEEP_CLKGATE_STATS_EN is defined.
module sleep_clkgate_ctrl
    import sleep_clkgate_pkg::*;
#(
    parameter int unsigned ENTRY_DLY = 8,
    parameter int unsigned WAKE_DLY  = 4,
    parameter bit          DEEP_ONLY = 1'b0
) (
    input  logic                FCLK,
    input  logic                PORESETn,
    input  logic                SLEEPING,
    input  logic                SLEEPDEEP,
    input  logic                GATE_ALLOW,
    input  logic                BUS_IDLE,
    input  logic                WAKEUP,
    input  logic                DBG_ACTIVE,
    output logic                HCLKEN,
    output logic                CLK_GATED,
    output logic [1:0]          SLEEP_STATE,
    input  logic                STATS_CLR,
    output logic [STATS_W-1:0]  GATED_CYCLES
);

    sleep_state_e     state_q;
    sleep_state_e     state_d;
    logic             hclken_q;
    logic             clk_gated_q;
    logic             gate_req;
    logic             cnt_load;
    logic [DLY_W-1:0] cnt_load_val;
    logic             cnt_dec;
    logic             cnt_zero;

    assign gate_req = SLEEPING & GATE_ALLOW & ~DBG_ACTIVE & ~WAKEUP
                    & (SLEEPDEEP | ~DEEP_ONLY);

    sleep_clkgate_dlycnt u_dlycnt (
        .clk      (FCLK),
        .rst_n    (PORESETn),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_d      = state_q;
        cnt_load     = 1'b0;
        cnt_load_val = DLY_W'(ENTRY_DLY);
        cnt_dec      = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                if (gate_req) begin
                    state_d  = ST_ENTRY;
                    cnt_load = 1'b1;
                end
            end
            ST_ENTRY: begin
                // Abort outranks an expired count; bus activity restarts the wait.
                if (!gate_req) begin
                    state_d = ST_RUN;
                end else if (!BUS_IDLE) begin
                    cnt_load = 1'b1;
                end else if (cnt_zero) begin
                    state_d = ST_GATED;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_GATED: begin
                if (!gate_req) begin
                    state_d      = ST_WAKE;
                    cnt_load     = 1'b1;
                    cnt_load_val = DLY_W'(WAKE_DLY);
                end
            end
            ST_WAKE: begin
                if (cnt_zero) begin
                    state_d = ST_RUN;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // Outputs load from next state so they switch on the same edge as the FSM.
    always_ff @(posedge FCLK or negedge PORESETn) begin
        if (!PORESETn) begin
            state_q     <= ST_RUN;
            hclken_q    <= 1'b1;
            clk_gated_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            hclken_q    <= (state_d != ST_GATED);
            clk_gated_q <= (state_d == ST_GATED);
        end
    end

    assign HCLKEN      = hclken_q;
    assign CLK_GATED   = clk_gated_q;
    assign SLEEP_STATE = state_q;

`ifdef SLEEP_CLKGATE_STATS_EN
    logic [STATS_W-1:0] gated_cycles_q;
    logic [STATS_W-1:0] gated_cycles_d;

    always_comb begin
        gated_cycles_d = gated_cycles_q;
        if (STATS_CLR) begin
            gated_cycles_d = '0;
        end else if ((state_q == ST_GATED) && (gated_cycles_q != '1)) begin
            gated_cycles_d = gated_cycles_q + STATS_W'(1);
        end
    end

    always_ff @(posedge FCLK or negedge PORESETn) begin
        if (!PORESETn) begin
            gated_cycles_q <= '0;
        end else begin
            gated_cycles_q <= gated_cycles_d;
        end
    end

    assign GATED_CYCLES = gated_cycles_q;
`else
    logic stats_clr_unused;
    assign stats_clr_unused = STATS_CLR;
    assign GATED_CYCLES     = '0;
`endif

endmodule

// File: tb/tb_sleep_clkgate_ctrl.sv
// Self-checking bench for sleep_clkgate_ctrl: vector table, corner sequences, random vs model.
module tb_sleep_clkgate_ctrl;

    localparam int ENTRY_DLY = 4;
    localparam int WAKE_DLY  = 2;

    logic        fclk = 1'b0;
    logic        poresetn;
    logic        sleeping, sleepdeep, gate_allow, bus_idle, wakeup, dbg_active, stats_clr;
    logic        hclken, clk_gated;
    logic [1:0]  sleep_state;
    logic [15:0] gated_cycles;
    logic        d_hclken, d_clk_gated;
    logic [1:0]  d_sleep_state;
    logic [15:0] d_gated_cycles;

    int checks = 0;
    int errors = 0;

    always #5 fclk = ~fclk;

    sleep_clkgate_ctrl #(.ENTRY_DLY(ENTRY_DLY), .WAKE_DLY(WAKE_DLY), .DEEP_ONLY(1'b0)) u_dut (
        .FCLK(fclk), .PORESETn(poresetn), .SLEEPING(sleeping), .SLEEPDEEP(sleepdeep),
        .GATE_ALLOW(gate_allow), .BUS_IDLE(bus_idle), .WAKEUP(wakeup), .DBG_ACTIVE(dbg_active),
        .HCLKEN(hclken), .CLK_GATED(clk_gated), .SLEEP_STATE(sleep_state),
        .STATS_CLR(stats_clr), .GATED_CYCLES(gated_cycles)
    );

    sleep_clkgate_ctrl #(.ENTRY_DLY(ENTRY_DLY), .WAKE_DLY(WAKE_DLY), .DEEP_ONLY(1'b1)) u_deep (
        .FCLK(fclk), .PORESETn(poresetn), .SLEEPING(sleeping), .SLEEPDEEP(sleepdeep),
        .GATE_ALLOW(gate_allow), .BUS_IDLE(bus_idle), .WAKEUP(wakeup), .DBG_ACTIVE(dbg_active),
        .HCLKEN(d_hclken), .CLK_GATED(d_clk_gated), .SLEEP_STATE(d_sleep_state),
        .STATS_CLR(stats_clr), .GATED_CYCLES(d_gated_cycles)
    );

    // Reference model for the main instance: modes run/entry/gated/wake, delays counted upward.
    int  m_mode;
    int  m_idle_run;
    int  m_wake_run;
    int  m_gcnt;
    bit  m_req;

    always @(posedge fclk or negedge poresetn) begin
        if (!poresetn) begin
            m_mode = 0; m_idle_run = 0; m_wake_run = 0; m_gcnt = 0;
        end else begin
            m_req = sleeping && gate_allow && !dbg_active && !wakeup;
`ifdef SLEEP_CLKGATE_STATS_EN
            if (stats_clr) m_gcnt = 0;
            else if (m_mode == 2 && m_gcnt < 65535) m_gcnt = m_gcnt + 1;
`endif
            case (m_mode)
                0: if (m_req) begin m_mode = 1; m_idle_run = 0; end
                1: begin
                    if (!m_req) m_mode = 0;
                    else if (!bus_idle) m_idle_run = 0;
                    else if (m_idle_run >= ENTRY_DLY) m_mode = 2;
                    else m_idle_run = m_idle_run + 1;
                end
                2: if (!m_req) begin m_mode = 3; m_wake_run = 0; end
                default: begin
                    if (m_wake_run >= WAKE_DLY) m_mode = 0;
                    else m_wake_run = m_wake_run + 1;
                end
            endcase
        end
    end

    typedef struct {
        logic       s, a, i, w, d;
        logic       exp_hclken, exp_gated;
        logic [1:0] exp_state;
    } vec_t;

    vec_t vecs[15];

    function automatic vec_t mk(logic s, logic a, logic i, logic w, logic d,
                                logic h, logic g, logic [1:0] st);
        vec_t v;
        v.s = s; v.a = a; v.i = i; v.w = w; v.d = d;
        v.exp_hclken = h; v.exp_gated = g; v.exp_state = st;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge fclk);
        #1;
    endtask

    task automatic set_in(input logic s, input logic a, input logic i,
                          input logic w, input logic d);
        sleeping = s; gate_allow = a; bus_idle = i; wakeup = w; dbg_active = d;
    endtask

    logic saw_low;

    initial begin
        poresetn = 1'b0; stats_clr = 1'b0; sleepdeep = 1'b0;
        set_in(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

        vecs[0]  = mk(1,1,1,0,0, 1,0,2'b01);
        vecs[1]  = mk(1,1,1,0,0, 1,0,2'b01);
        vecs[2]  = mk(1,1,1,0,0, 1,0,2'b01);
        vecs[3]  = mk(1,1,1,0,0, 1,0,2'b01);
        vecs[4]  = mk(1,1,1,0,0, 1,0,2'b01);
        vecs[5]  = mk(1,1,1,0,0, 0,1,2'b10);
        vecs[6]  = mk(1,1,0,0,0, 0,1,2'b10);
        vecs[7]  = mk(1,1,1,1,0, 1,0,2'b11);
        vecs[8]  = mk(1,1,1,0,0, 1,0,2'b11);
        vecs[9]  = mk(1,1,1,0,0, 1,0,2'b11);
        vecs[10] = mk(1,1,1,0,0, 1,0,2'b00);
        vecs[11] = mk(1,1,1,0,0, 1,0,2'b01);
        vecs[12] = mk(0,1,1,0,0, 1,0,2'b00);
        vecs[13] = mk(1,1,1,0,1, 1,0,2'b00);
        vecs[14] = mk(1,1,1,0,1, 1,0,2'b00);

        tick(); tick();
        chk("rst_hclken", hclken, 1'b1);
        chk("rst_gated", clk_gated, 1'b0);
        chk("rst_state", sleep_state, 2'b00);
        chk("rst_gcnt", gated_cycles, 16'h0000);
        poresetn = 1'b1;
        tick();

        for (int k = 0; k < 15; k++) begin
            set_in(vecs[k].s, vecs[k].a, vecs[k].i, vecs[k].w, vecs[k].d);
            tick();
            chk($sformatf("vec%0d_hclken", k), hclken, vecs[k].exp_hclken);
            chk($sformatf("vec%0d_gated", k), clk_gated, vecs[k].exp_gated);
            chk($sformatf("vec%0d_state", k), sleep_state, vecs[k].exp_state);
        end

        for (int k = 0; k < 12; k++) begin
            tick();
            chk("dbg_hold_hclken", hclken, 1'b1);
            chk("dbg_hold_state", sleep_state, 2'b00);
        end

        // Bus activity in ENTRY restarts the entry delay.
        set_in(1, 1, 1, 0, 0);
        tick(); tick(); tick();
        chk("busdrop_pre_state", sleep_state, 2'b01);
        bus_idle = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("busdrop_hold_state", sleep_state, 2'b01);
        end
        bus_idle = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("busdrop_count_state", sleep_state, 2'b01);
        end
        tick();
        chk("busdrop_gated_state", sleep_state, 2'b10);
        chk("busdrop_gated_hclken", hclken, 1'b0);

        wakeup = 1'b1;
        tick();
        wakeup = 1'b0;
        chk("wake_hclken", hclken, 1'b1);
        for (int n = 0; n < 10 && sleep_state != 2'b00; n++) tick();
        chk("wake_back_run", sleep_state, 2'b00);

        // Wake source arrives on the edge the entry count would expire.
        saw_low = 1'b0;
        tick();
        chk("race_entry_state", sleep_state, 2'b01);
        for (int k = 0; k < 4; k++) begin
            tick();
            if (!hclken) saw_low = 1'b1;
        end
        wakeup = 1'b1;
        tick();
        if (!hclken) saw_low = 1'b1;
        chk("race_state", sleep_state, 2'b00);
        chk("race_hclken_low_seen", saw_low, 1'b0);
        set_in(0, 1, 1, 0, 0);
        tick();

        // Asynchronous reset while gated.
        set_in(1, 1, 1, 0, 0);
        for (int n = 0; n < 20 && hclken; n++) tick();
        chk("arst_pre_hclken", hclken, 1'b0);
        #2 poresetn = 1'b0;
        #1;
        chk("arst_hclken", hclken, 1'b1);
        chk("arst_state", sleep_state, 2'b00);
        chk("arst_gated", clk_gated, 1'b0);
        #1 poresetn = 1'b1;
        set_in(0, 1, 1, 0, 0);
        tick();

        // Deep-only instance needs SLEEPDEEP.
        sleepdeep = 1'b0;
        set_in(1, 1, 1, 0, 0);
        for (int k = 0; k < 12; k++) begin
            tick();
            chk("deep_hold_state", d_sleep_state, 2'b00);
            chk("deep_hold_hclken", d_hclken, 1'b1);
        end
        sleepdeep = 1'b1;
        tick();
        chk("deep_entry_state", d_sleep_state, 2'b01);

        for (int k = 0; k < 3000; k++) begin
            sleeping   = ($urandom_range(0, 9) != 0);
            gate_allow = ($urandom_range(0, 9) != 0);
            bus_idle   = ($urandom_range(0, 4) != 0);
            wakeup     = ($urandom_range(0, 19) == 0);
            dbg_active = ($urandom_range(0, 29) == 0);
            sleepdeep  = $urandom_range(0, 1) == 1;
            stats_clr  = ($urandom_range(0, 49) == 0);
            tick();
            chk("rnd_hclken", hclken, (m_mode != 2));
            chk("rnd_gated", clk_gated, (m_mode == 2));
            chk("rnd_state", sleep_state, m_mode[1:0]);
            chk("rnd_gcnt", gated_cycles, m_gcnt[15:0]);
        end

        // Gated-cycle statistics.
        stats_clr = 1'b0;
        set_in(0, 1, 1, 0, 0);
        for (int n = 0; n < 10 && sleep_state != 2'b00; n++) tick();
        stats_clr = 1'b1;
        tick();
        stats_clr = 1'b0;
        set_in(1, 1, 1, 0, 0);
        for (int n = 0; n < 20 && !clk_gated; n++) tick();
        chk("stats_pre_gated", clk_gated, 1'b1);
        repeat (10) tick();
`ifdef SLEEP_CLKGATE_STATS_EN
        chk("stats_ten", gated_cycles, 16'd10);
        stats_clr = 1'b1;
        tick();
        stats_clr = 1'b0;
        chk("stats_clear", gated_cycles, 16'd0);
        repeat (70000) @(posedge fclk);
        #1;
        chk("stats_saturate", gated_cycles, 16'hFFFF);
`else
        chk("stats_tied_zero", gated_cycles, 16'd0);
        stats_clr = 1'b1;
        tick();
        stats_clr = 1'b0;
        chk("stats_tied_zero_clr", gated_cycles, 16'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sleep_clkgate_ctrl.md
Name: sleep_clkgate_ctrl

Overview:
Sleep-aware clock-gating controller, the stage directly upstream of the clock gating cell. It runs on the free-running FCLK and watches the Cortex-M sleep status, bus idleness and wake sources. It drives HCLKEN, which feeds the gate cell's CLKEN input to produce gated HCLK. It adds a programmable entry delay before gating and a wake settling delay after ungating.

Parameters:
ENTRY_DLY, 8, FCLK cycles of continuous BUS_IDLE required in ENTRY before gating (0..255)
WAKE_DLY, 4, FCLK cycles held in WAKE after ungating before re-arming (0..255)
DEEP_ONLY, 0, 1 = gate only when SLEEPDEEP is also high

Ports:
FCLK  in  1  free-running clock, never gated
PORESETn  in  1  asynchronous active-low reset
SLEEPING  in  1  core sleep status
SLEEPDEEP  in  1  core deep-sleep status
GATE_ALLOW  in  1  software enable for gating (register bit)
BUS_IDLE  in  1  no outstanding bus transfer
WAKEUP  in  1  pending interrupt/event, already synchronised to FCLK
DBG_ACTIVE  in  1  debugger attached; inhibits gating
HCLKEN  out  1  clock enable to gate cell, registered
CLK_GATED  out  1  status, high while in GATED
SLEEP_STATE  out  2  current FSM state encoding
STATS_CLR  in  1  clear gated-cycle counter (optional feature)
GATED_CYCLES  out  16  gated-cycle count (optional feature)

Behaviour:
- Reset (async, PORESETn=0): state=RUN, HCLKEN=1, CLK_GATED=0, SLEEP_STATE=2'b00, delay counter=0, GATED_CYCLES=0.
- Signals:
  - gate_req = SLEEPING & GATE_ALLOW & ~DBG_ACTIVE & ~WAKEUP & (SLEEPDEEP | ~DEEP_ONLY).
  - abort = ~gate_req.
- RUN: if gate_req, go to ENTRY and load cnt=ENTRY_DLY.
- ENTRY:
  - abort → RUN.
  - Otherwise, if ~BUS_IDLE, reload cnt=ENTRY_DLY.
  - Otherwise, if cnt==0, go to GATED.
  - Otherwise, cnt--.
- GATED: if abort (any wake source, or sleep/allow dropped), go to WAKE and load cnt=WAKE_DLY. BUS_IDLE is ignored.
- WAKE: if cnt==0, go to RUN; otherwise cnt--. gate_req is ignored in WAKE; re-entry is possible only from RUN.
- HCLKEN and CLK_GATED are flops loaded from next_state, so they are glitch-free and change on the same edge as the state. HCLKEN=0 exactly when state==GATED.
- Entry latency: if gate_req is sampled high at edge k with BUS_IDLE steady high, state=ENTRY after k and GATED/HCLKEN=0 after edge k+1+ENTRY_DLY.
- Wake latency: if WAKEUP is sampled at edge m while in GATED, HCLKEN=1 after edge m. State returns to RUN after edge m+1+WAKE_DLY.
- Simultaneous events:
  - abort and cnt==0 in ENTRY: abort wins, go to RUN.
  - WAKEUP on the same cycle as a RUN→ENTRY request: stay in RUN, since gate_req is 0.
- Reset mid-GATED: HCLKEN returns to 1 immediately (asynchronously).
- Counter is 8 bits. It never underflows, because it is only decremented when non-zero.

Optional Feature:
- Macro: SLEEP_CLKGATE_STATS_EN.
- Defined:
  - 16-bit GATED_CYCLES increments on each FCLK edge where state==GATED and saturates at 16'hFFFF.
  - STATS_CLR=1 forces it to 0; clear has priority over increment.
- Undefined: GATED_CYCLES is tied to 0, STATS_CLR is ignored, and no counter logic is built.

Decomposition:
- Package sleep_clkgate_pkg:
  - State encodings: RUN=2'b00, ENTRY=2'b01, GATED=2'b10, WAKE=2'b11.
  - DLY_W=8, STATS_W=16.
- One natural sub-module, sleep_clkgate_dlycnt: an 8-bit loadable down-counter with load, dec and zero-flag outputs, used for both delays.
- The clock gating cell is instantiated by the parent, not inside this block.

Test Plan (ENTRY_DLY=4, WAKE_DLY=2, DEEP_ONLY=0 unless noted):
- Reset released; SLEEPING=1, GATE_ALLOW=1, BUS_IDLE=1 at edge k → ENTRY after k, HCLKEN=0 and CLK_GATED=1 after edge k+5, SLEEP_STATE=2'b10.
- In GATED, pulse WAKEUP one cycle at edge m → HCLKEN=1 after m, SLEEP_STATE=2'b11, RUN after m+3.
- In ENTRY, drop BUS_IDLE at cycle 2 for 3 cycles → counter reloads; GATED is reached 5 cycles after BUS_IDLE returns high.
- DBG_ACTIVE=1 with SLEEPING=1 → state stays RUN, HCLKEN stays 1 indefinitely. DEEP_ONLY=1 with SLEEPDEEP=0 → same result.
- WAKEUP on the exact edge where ENTRY cnt==0 → RUN, HCLKEN never drops. PORESETn asserted while GATED → HCLKEN=1 without waiting for an FCLK edge.
- With SLEEP_CLKGATE_STATS_EN: stay GATED for 10 cycles → GATED_CYCLES=10. STATS_CLR=1 → 0. Force 70000 gated cycles → saturates at 16'hFFFF.
